time_set_ctrl: RTL and testbench

Set-mode controller that drives the control inputs of the clock's hour, minute and second counters from the front-panel buttons. It walks the user through the fields with a mode button and emits single-cycle step or clear strobes. In the alarm-clock datapath it sits between the debounced button block and the field counters. It owns the enable, up/down and load side of the counter interface.

---
 rtl/time_set_pkg.sv | 37 +++
 rtl/btn_repeat.sv | 108 ++++++++++
 rtl/time_set_ctrl.sv | 204 ++++++++++++++++++++
 tb/tb_time_set_ctrl.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/time_set_pkg.sv
// time_set_pkg: shared constants for the time-set controller.
//   - State codes (also the value driven on the `field` output):
//     ST_RUN=0, ST_HR=1, ST_MIN=2, ST_SEC=3.
//   - Direction codes for the `ud` qualifier: UD_UP=0, UD_DN=1.
//   - Elaboration helpers used to size-check the tick timers.
package time_set_pkg;

  localparam logic [1:0] ST_RUN = 2'd0;
  localparam logic [1:0] ST_HR  = 2'd1;
  localparam logic [1:0] ST_MIN = 2'd2;
  localparam logic [1:0] ST_SEC = 2'd3;

  localparam logic UD_UP = 1'b0;
  localparam logic UD_DN = 1'b1;

  // Largest of three timer limits.
  function automatic int unsigned tmax3(input int unsigned a,
                                        input int unsigned b,
                                        input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

  // True when `value` can be represented in `width` unsigned bits.
  function automatic bit fits_width(input int unsigned value,
                                    input int unsigned width);
    if (width >= 32'd32) begin
      return 1'b1;
    end else begin
      return (value < (32'd1 << width));
    end
  endfunction

endpackage

// File: rtl/btn_repeat.sv
// btn_repeat: press detector plus optional hold-to-repeat timer for one
// front-panel button.
//
// Build option: TIME_SET_AUTOREPEAT_EN adds the hold/repeat timer and the
// tick/clr ports; without it the block only reports presses.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   tick         one-cycle timebase strobe        (repeat build only)
//   clr          clear the repeat timer           (repeat build only)
//   level        debounced button level
//   block        conflicting button also held: suppress step, zero timer
//   step         combinational one-cycle step request (press or repeat)
module btn_repeat
`ifdef TIME_SET_AUTOREPEAT_EN
#(
  parameter int unsigned RPT_DLY = 8,
  parameter int unsigned RPT_PER = 2,
  parameter int unsigned CW      = 6
)
`endif
(
  input  logic clk,
  input  logic rst_n,
`ifdef TIME_SET_AUTOREPEAT_EN
  input  logic tick,
  input  logic clr,
`endif
  input  logic level,
  input  logic block,
  output logic step
);

  logic prev;
  logic armed;
  logic press;

  // Previous level and arming flag. The flag only sets once the level has
  // been seen low, so a button already held through reset is not a press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev  <= 1'b0;
      armed <= 1'b0;
    end else begin
      prev  <= level;
      armed <= armed | ~level;
    end
  end

  assign press = level & ~prev & armed;

`ifdef TIME_SET_AUTOREPEAT_EN
  logic          holding;
  logic          rpt_phase;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_inc;
  logic          rpt;

  assign cnt_inc = cnt + {{(CW-1){1'b0}}, 1'b1};

  // A repeat fires on the tick that completes the initial delay, then on
  // every period after that, as long as the hold is uninterrupted.
  always_comb begin
    rpt = 1'b0;
    if (holding && level && tick && !block && !clr) begin
      if (rpt_phase) begin
        rpt = (cnt_inc == CW'(RPT_PER));
      end else begin
        rpt = (cnt_inc == CW'(RPT_DLY));
      end
    end else begin
      rpt = 1'b0;
    end
  end

  // Hold tracking and tick counter. Only a genuine press starts a hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      holding   <= 1'b0;
      rpt_phase <= 1'b0;
      cnt       <= {CW{1'b0}};
    end else if (!level) begin
      holding   <= 1'b0;
      rpt_phase <= 1'b0;
      cnt       <= {CW{1'b0}};
    end else if (press) begin
      holding   <= 1'b1;
      rpt_phase <= 1'b0;
      cnt       <= {CW{1'b0}};
    end else if (block || clr) begin
      rpt_phase <= 1'b0;
      cnt       <= {CW{1'b0}};
    end else if (holding && tick) begin
      if (rpt) begin
        rpt_phase <= 1'b1;
        cnt       <= {CW{1'b0}};
      end else begin
        cnt       <= cnt_inc;
      end
    end
  end

  assign step = (press | rpt) & ~block;
`else
  assign step = press & ~block;
`endif

endmodule

// File: rtl/time_set_ctrl.sv
// time_set_ctrl: set-mode controller for the clock's hour/minute/second
// counters. The mode button walks RUN -> HR -> MIN -> SEC -> RUN; up/down
// presses become one-cycle step strobes for the selected field, or a
// seconds clear in SEC. An idle timeout returns to RUN.
//
// Build option: TIME_SET_AUTOREPEAT_EN enables hold-to-repeat on up/down.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   tick              one-cycle timebase strobe
//   btn_mode/up/down  debounced button levels
//   set_active        high in any set state
//   field             0 RUN, 1 hours, 2 minutes, 3 seconds
//   en_hr, en_min     one-cycle step strobes, direction on ud (0 up, 1 down)
//   ld_sec            one-cycle strobe loading zero into seconds
module time_set_ctrl
  import time_set_pkg::*;
#(
  parameter int unsigned TO_TICKS = 30,
  parameter int unsigned RPT_DLY  = 8,
  parameter int unsigned RPT_PER  = 2,
  parameter int unsigned CW       = 6
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       btn_mode,
  input  logic       btn_up,
  input  logic       btn_down,
  output logic       set_active,
  output logic [1:0] field,
  output logic       en_hr,
  output logic       en_min,
  output logic       ud,
  output logic       ld_sec
);

  // If CW is too narrow for the configured limits, the idle timer falls
  // back to its all-ones value so the timeout still happens.
  localparam int unsigned   TIMER_MAX = tmax3(TO_TICKS, RPT_DLY, RPT_PER);
  localparam bit            CW_FITS   = fits_width(TIMER_MAX, CW);
  localparam logic [CW-1:0] TO_CNT    = CW_FITS ? CW'(TO_TICKS) : {CW{1'b1}};

  logic [1:0]    state;
  logic [1:0]    state_nx;
  logic          state_chg;
  logic          mode_prev;
  logic          mode_armed;
  logic          mode_press;
  logic          up_step;
  logic          dn_step;
  logic          both_hi;
  logic          button_hi;
  logic          strobe_q;
  logic          timeout;
  logic [CW-1:0] idle;
  logic [CW-1:0] idle_nx;
  logic [CW-1:0] idle_inc;
  logic          en_hr_nx;
  logic          en_min_nx;
  logic          ld_sec_nx;
  logic          ud_nx;

  assign both_hi   = btn_up & btn_down;
  assign button_hi = btn_mode | btn_up | btn_down;
  assign strobe_q  = en_hr | en_min | ld_sec;
  assign idle_inc  = idle + {{(CW-1){1'b0}}, 1'b1};
  assign field     = state;

  // Mode press detector; a mode level held through reset is not a press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_prev  <= 1'b0;
      mode_armed <= 1'b0;
    end else begin
      mode_prev  <= btn_mode;
      mode_armed <= mode_armed | ~btn_mode;
    end
  end

  assign mode_press = btn_mode & ~mode_prev & mode_armed;

  // The timeout is independent of the up/down steps so the repeat-timer
  // clear never loops back through the step logic.
  assign timeout   = (state != ST_RUN) & ~mode_press & tick & ~button_hi &
                     (idle_inc == TO_CNT);
  assign state_chg = mode_press | timeout;

  btn_repeat
`ifdef TIME_SET_AUTOREPEAT_EN
  #(.RPT_DLY(RPT_DLY), .RPT_PER(RPT_PER), .CW(CW))
`endif
  u_up (
    .clk   (clk),
    .rst_n (rst_n),
`ifdef TIME_SET_AUTOREPEAT_EN
    .tick  (tick),
    .clr   (state_chg),
`endif
    .level (btn_up),
    .block (both_hi),
    .step  (up_step)
  );

  btn_repeat
`ifdef TIME_SET_AUTOREPEAT_EN
  #(.RPT_DLY(RPT_DLY), .RPT_PER(RPT_PER), .CW(CW))
`endif
  u_dn (
    .clk   (clk),
    .rst_n (rst_n),
`ifdef TIME_SET_AUTOREPEAT_EN
    .tick  (tick),
    .clr   (state_chg),
`endif
    .level (btn_down),
    .block (both_hi),
    .step  (dn_step)
  );

  // Next state: mode press advances, timeout returns to RUN.
  always_comb begin
    state_nx = state;
    if (mode_press) begin
      case (state)
        ST_RUN:  state_nx = ST_HR;
        ST_HR:   state_nx = ST_MIN;
        ST_MIN:  state_nx = ST_SEC;
        ST_SEC:  state_nx = ST_RUN;
        default: state_nx = ST_RUN;
      endcase
    end else if (timeout) begin
      state_nx = ST_RUN;
    end else begin
      state_nx = state;
    end
  end

  // Idle counter: cleared by presses, by RUN and by the timeout itself;
  // advanced by ticks while no button is held.
  always_comb begin
    idle_nx = idle;
    if (mode_press || (state == ST_RUN) || up_step || dn_step || timeout) begin
      idle_nx = {CW{1'b0}};
    end else if (tick && !button_hi) begin
      idle_nx = idle_inc;
    end else begin
      idle_nx = idle;
    end
  end

  // Strobe decode. A mode press drops any coincident step; a strobe still
  // high from the previous cycle holds off the next one.
  always_comb begin
    en_hr_nx  = 1'b0;
    en_min_nx = 1'b0;
    ld_sec_nx = 1'b0;
    ud_nx     = ud;
    if (!mode_press && (up_step || dn_step) && !strobe_q) begin
      case (state)
        ST_HR: begin
          en_hr_nx = 1'b1;
          ud_nx    = dn_step ? UD_DN : UD_UP;
        end
        ST_MIN: begin
          en_min_nx = 1'b1;
          ud_nx     = dn_step ? UD_DN : UD_UP;
        end
        ST_SEC: begin
          ld_sec_nx = 1'b1;
        end
        default: begin
          ud_nx = ud;
        end
      endcase
    end else begin
      ud_nx = ud;
    end
  end

  // State, idle timer and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_RUN;
      idle       <= {CW{1'b0}};
      set_active <= 1'b0;
      en_hr      <= 1'b0;
      en_min     <= 1'b0;
      ld_sec     <= 1'b0;
      ud         <= UD_UP;
    end else begin
      if (state_chg) begin
        state <= state_nx;
      end
      idle       <= idle_nx;
      set_active <= (state_nx != ST_RUN);
      en_hr      <= en_hr_nx;
      en_min     <= en_min_nx;
      ld_sec     <= ld_sec_nx;
      ud         <= ud_nx;
    end
  end

endmodule

// File: tb/tb_time_set_ctrl.sv
// tb_time_set_ctrl: directed and randomized bench for time_set_ctrl with a
// behavioural reference model (field index, idle tick count, ticks held).
module tb_time_set_ctrl;

  localparam int TO  = 30;
  localparam int DLY = 8;
  localparam int PER = 2;
`ifdef TIME_SET_AUTOREPEAT_EN
  localparam int EXP_HOLD = 5;
`else
  localparam int EXP_HOLD = 1;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick = 1'b0;
  logic       btn_mode = 1'b0;
  logic       btn_up = 1'b0;
  logic       btn_down = 1'b0;
  logic       set_active;
  logic [1:0] field;
  logic       en_hr;
  logic       en_min;
  logic       ud;
  logic       ld_sec;

  int checks = 0;
  int failures = 0;
  int n_hr = 0;
  int n_min = 0;
  int n_sec = 0;

  // reference model state
  int m_field;
  int m_idle;
  int hu;
  int hd;
  bit m_en_hr, m_en_min, m_ld_sec, m_ud;
  bit pm, pu, pd, am, au, ad;

  time_set_ctrl #(.TO_TICKS(30), .RPT_DLY(8), .RPT_PER(2), .CW(6)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tick       (tick),
    .btn_mode   (btn_mode),
    .btn_up     (btn_up),
    .btn_down   (btn_down),
    .set_active (set_active),
    .field      (field),
    .en_hr      (en_hr),
    .en_min     (en_min),
    .ud         (ud),
    .ld_sec     (ld_sec)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] dut_outs();
    return {set_active, field, en_hr, en_min, ud, ld_sec};
  endfunction

  function automatic logic [6:0] model_outs();
    logic [1:0] f;
    f = 2'(m_field);
    return {(m_field != 0), f, m_en_hr, m_en_min, m_ud, m_ld_sec};
  endfunction

  task automatic model_reset();
    m_field = 0; m_idle = 0; hu = -1; hd = -1;
    m_en_hr = 1'b0; m_en_min = 1'b0; m_ld_sec = 1'b0; m_ud = 1'b0;
    pm = 1'b0; pu = 1'b0; pd = 1'b0; am = 1'b0; au = 1'b0; ad = 1'b0;
  endtask

  // Hold model: h counts ticks since the press (-1 = no hold in progress).
  task automatic rep_model(input bit lvl, input bit edg, input bit both, input bit chg,
                           inout int h, output bit r);
    r = 1'b0;
    if (!lvl) h = -1;
    else if (edg) h = 0;
    else if (h >= 0) begin
      if (both || chg) h = 0;
      else if (tick) begin
        h = h + 1;
`ifdef TIME_SET_AUTOREPEAT_EN
        r = (h >= DLY) && (((h - DLY) % PER) == 0);
`endif
      end
    end
  endtask

  task automatic model_update();
    bit mp, ue, de, both, anyhi, in_set, tmo, chg, ru, rd, su, sd, prev_strobe;
    if (!rst_n) begin
      model_reset();
      return;
    end
    mp     = btn_mode && !pm && am;
    ue     = btn_up && !pu && au;
    de     = btn_down && !pd && ad;
    both   = btn_up && btn_down;
    anyhi  = btn_mode || btn_up || btn_down;
    in_set = (m_field != 0);
    tmo    = in_set && !mp && tick && !anyhi && (m_idle + 1 == TO);
    chg    = mp || tmo;
    rep_model(btn_up, ue, both, chg, hu, ru);
    rep_model(btn_down, de, both, chg, hd, rd);
    su = (ue || ru) && !both;
    sd = (de || rd) && !both;
    prev_strobe = m_en_hr || m_en_min || m_ld_sec;
    m_en_hr = 1'b0; m_en_min = 1'b0; m_ld_sec = 1'b0;
    if (mp) begin
      m_field = (m_field + 1) % 4;
      m_idle = 0;
    end else if (!in_set) begin
      m_idle = 0;
    end else if (su || sd) begin
      m_idle = 0;
      if (!prev_strobe) begin
        if (m_field == 1) begin m_en_hr = 1'b1; m_ud = sd; end
        else if (m_field == 2) begin m_en_min = 1'b1; m_ud = sd; end
        else m_ld_sec = 1'b1;
      end
    end else if (tmo) begin
      m_field = 0;
      m_idle = 0;
    end else if (tick && !anyhi) begin
      m_idle = m_idle + 1;
    end
    pm = btn_mode; pu = btn_up; pd = btn_down;
    am = am || !btn_mode; au = au || !btn_up; ad = ad || !btn_down;
  endtask

  // One clock: drive inputs, update model at the edge, check at negedge.
  task automatic cyc(input bit m, input bit u, input bit d, input bit t);
    btn_mode = m; btn_up = u; btn_down = d; tick = t;
    @(posedge clk);
    model_update();
    @(negedge clk);
    check_eq("outs", 32'(dut_outs()), 32'(model_outs()));
    n_hr  += int'(en_hr);
    n_min += int'(en_min);
    n_sec += int'(ld_sec);
  endtask

  task automatic mode_press();
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic clear_counts();
    n_hr = 0; n_min = 0; n_sec = 0;
  endtask

  initial begin
    bit m, u, d, t;
    int act, thr;
    model_reset();
    @(negedge clk);
    check_eq("reset", 32'(dut_outs()), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);

    // field walk
    for (int k = 1; k <= 3; k++) begin
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      check_eq("field_walk", 32'(field), 32'(k));
      cyc(1'b0, 1'b0, 1'b0, 1'b0);
    end
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    check_eq("field_wrap", 32'({set_active, field}), 32'd0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);

    // minutes up/down
    mode_press();
    mode_press();
    clear_counts();
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    check_eq("min_up", 32'({en_min, ud}), 32'd2);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("min_up_single", 32'(en_min), 32'd0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    check_eq("min_dn", 32'({en_min, ud}), 32'd3);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("min_count", 32'(n_min), 32'd2);
    check_eq("hr_quiet", 32'(n_hr), 32'd0);

    // seconds clear and simultaneous up/down
    mode_press();
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    check_eq("sec_up", 32'({ld_sec, en_hr, en_min}), 32'd4);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    clear_counts();
    cyc(1'b0, 1'b1, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("sec_both", 32'(n_sec + n_hr + n_min), 32'd0);

    // hold up in hours for 14 ticks
    mode_press();
    mode_press();
    clear_counts();
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 14; k++) begin
      cyc(1'b0, 1'b1, 1'b0, 1'b0);
      cyc(1'b0, 1'b1, 1'b0, 1'b0);
      cyc(1'b0, 1'b1, 1'b0, 1'b1);
    end
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("hold_hr", 32'(n_hr), 32'(EXP_HOLD));

    // idle timeout with a restart at tick 29
    for (int k = 0; k < 28; k++) begin
      cyc(1'b0, 1'b0, 1'b0, 1'b1);
      cyc(1'b0, 1'b0, 1'b0, 1'b0);
    end
    cyc(1'b0, 1'b1, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 29; k++) begin
      cyc(1'b0, 1'b0, 1'b0, 1'b1);
      cyc(1'b0, 1'b0, 1'b0, 1'b0);
    end
    check_eq("no_timeout_29", 32'(field), 32'd1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    check_eq("timeout", 32'({set_active, field}), 32'd0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);

    // async reset mid-strobe while holding up
    mode_press();
    mode_press();
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    check_eq("min_before_rst", 32'(en_min), 32'd1);
    rst_n = 1'b0;
    #1;
    check_eq("rst_async", 32'(dut_outs()), 32'd0);
    model_reset();
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    rst_n = 1'b1;
    clear_counts();
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    check_eq("held_after_rst", 32'(n_hr + n_min + n_sec), 32'd0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("toggle_after_rst", 32'(n_hr), 32'd1);

    // randomized segments against the model
    for (int seg = 0; seg < 25; seg++) begin
      act = int'($urandom_range(0, 2));
      thr = (act == 1) ? 8 : 40;
      if ($urandom_range(0, 7) == 0) begin
        rst_n = 1'b0;
        cyc(btn_mode, btn_up, btn_down, 1'b0);
        rst_n = 1'b1;
      end
      for (int i = 0; i < 160; i++) begin
        m = btn_mode; u = btn_up; d = btn_down;
        if (act == 0) begin
          m = 1'b0; u = 1'b0; d = 1'b0;
        end else begin
          if ($urandom_range(0, thr - 1) == 0) m = !m;
          if ($urandom_range(0, thr - 1) == 0) u = !u;
          if ($urandom_range(0, thr - 1) == 0) d = !d;
        end
        t = ($urandom_range(0, 3) == 0);
        cyc(m, u, d, t);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
